// File: rtl/pdm_decoder.sv
// pdm_decoder: recovers multi-bit amplitude samples from a 1-bit density-modulated stream.
// The incoming bit is synchronised, and ones are counted over windows of 2^DECIM_LOG2
// qualified bits. One sample per window is delivered over a valid/ready handshake.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   data          in   1-bit stream, asynchronous to clk
//   en            in   bit strobe; the synchronised bit is counted only when en=1
//   clr           in   synchronous clear of window, sample_valid and overrun
//   sample        out  OUT_W-bit amplitude of the last completed window
//   sample_valid  out  sample holds an unconsumed value
//   sample_ready  in   consumer accepts sample when valid & ready at a clock edge
//   overrun       out  sticky flag: a completed window was dropped
module pdm_decoder #(
    parameter int unsigned DECIM_LOG2 = 8,
    parameter int unsigned OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             en,
    input  logic             clr,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    localparam int unsigned CNT_W  = DECIM_LOG2;
    localparam int unsigned ONES_W = DECIM_LOG2 + 1;

    // Last bit index of a window (R-1) and the saturation ceiling (R-1) in ones width.
    localparam logic [CNT_W-1:0]  LAST_BIT = {CNT_W{1'b1}};
    localparam logic [ONES_W-1:0] SAT_MAX  = {1'b0, {CNT_W{1'b1}}};

    logic              r_sync1;
    logic              r_sync2;
    logic [1:0]        r_prime;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [ONES_W-1:0] r_ones;
    logic [OUT_W-1:0]  r_sample;
    logic              r_valid;
    logic              r_overrun;

    logic              w_qual;
    logic              w_win_end;
    logic [ONES_W-1:0] w_total;
    logic [CNT_W-1:0]  w_sat;
    logic [OUT_W-1:0]  w_sample_nxt;
    logic              w_accept;
    logic              w_load;

    // Counting is held off until the synchroniser has been filled with real stream
    // bits after reset, so the first window is made of R genuine input bits.
    assign w_qual       = en & r_prime[1];
    assign w_win_end    = w_qual & (r_bitcnt == LAST_BIT);
    assign w_total      = r_ones + ONES_W'(r_sync2);
    // An all-ones window (total == R) does not fit; clamp it to R-1.
    assign w_sat        = (w_total > SAT_MAX) ? SAT_MAX[CNT_W-1:0] : w_total[CNT_W-1:0];
    assign w_sample_nxt = w_sat[CNT_W-1 -: OUT_W];
    assign w_accept     = r_valid & sample_ready;
    assign w_load       = w_win_end & (~r_valid | sample_ready);

    // Two-flop synchroniser plus fill tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prime <= 2'b00;
        end else begin
            r_sync1 <= data;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    // Window counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt <= '0;
            r_ones   <= '0;
        end else if (clr) begin
            r_bitcnt <= '0;
            r_ones   <= '0;
        end else if (w_qual) begin
            r_bitcnt <= r_bitcnt + CNT_W'(1);
            r_ones   <= w_win_end ? '0 : w_total;
        end
    end

    // Output sample register and handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_win_end) begin
            if (w_load) begin
                r_sample <= w_sample_nxt;
                r_valid  <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_pdm_decoder.sv
// Testbench for pdm_decoder: directed stimulus with a queue-based scoreboard.
// A default instance (OUT_W=8) and a narrow instance (OUT_W=6) share all inputs.
module tb_pdm_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       data;
    logic       en;
    logic       clr;
    logic       sample_ready;
    logic [7:0] sample;
    logic       sample_valid;
    logic       overrun;
    logic [5:0] sample6;
    logic       valid6;
    logic       overrun6;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] s8;
        logic [5:0] s6;
    } exp_t;
    exp_t exp_q[$];

    int data_mode = 1;   // 0: constant 0, 1: constant 1, 2: alternating
    int en_mode   = 0;   // 0: en always high, 1: en high one cycle in four
    int ecnt      = 0;

    always #5 clk = ~clk;

    pdm_decoder #(.DECIM_LOG2(8), .OUT_W(8)) u_dut (
        .clk(clk), .rst(rst), .data(data), .en(en), .clr(clr),
        .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun)
    );

    pdm_decoder #(.DECIM_LOG2(8), .OUT_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .data(data), .en(en), .clr(clr),
        .sample(sample6), .sample_valid(valid6),
        .sample_ready(sample_ready), .overrun(overrun6)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] s8, input logic [5:0] s6, input int n);
        exp_t e;
        e.s8 = s8;
        e.s6 = s6;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Counts rising edges until sample_valid is seen high (sampled on the falling edge).
    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!sample_valid && n < max);
        if (!sample_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        rst          = 1'b0;
        clr          = 1'b0;
        sample_ready = rdy;
        repeat (3) @(posedge clk);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        #1;
        rst = 1'b1;
    endtask

    // Stream and strobe driver.
    initial begin
        data = 1'b0;
        en   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ecnt++;
            case (data_mode)
                0:       data = 1'b0;
                1:       data = 1'b1;
                default: data = ~data;
            endcase
            en = (en_mode == 1) ? ((ecnt % 4) == 0) : 1'b1;
        end
    end

    // Scoreboard monitor: each accepted sample is checked against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample: got %0d expected none", sample);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample8", int'(sample), int'(e.s8));
                    chk("sample6", int'(sample6), int'(e.s6));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b0;
        clr          = 1'b0;
        sample_ready = 1'b1;

        // All ones: saturated full-scale sample, first after 258 cycles, then every 256.
        data_mode = 1; en_mode = 0;
        do_reset(1'b1);
        push_exp(8'd255, 6'd63, 2);
        wait_valid(400, n);
        chk("t1_first_latency", n, 258);
        wait_valid(400, n);
        chk("t1_period", n, 256);

        // All zeros: zero sample, no overrun.
        data_mode = 0;
        do_reset(1'b1);
        push_exp(8'd0, 6'd0, 2);
        wait_valid(400, n);
        chk("t2_first_latency", n, 258);
        wait_valid(400, n);
        chk("t2_period", n, 256);
        chk("t2_overrun", int'(overrun), 0);

        // Alternating bits: half scale.
        data_mode = 2;
        do_reset(1'b1);
        push_exp(8'd128, 6'd32, 1);
        wait_valid(400, n);
        chk("t3_latency", n, 258);

        // Back-pressure over two windows: first held, second dropped, then clr.
        data_mode = 1;
        do_reset(1'b0);
        wait_valid(400, n);
        chk("t4_latency", n, 258);
        chk("t4_held_first", int'(sample), 255);
        data_mode = 0;
        repeat (255) @(posedge clk);
        @(negedge clk);
        chk("t4_no_overrun_yet", int'(overrun), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t4_overrun", int'(overrun), 1);
        chk("t4_sample_held", int'(sample), 255);
        chk("t4_valid_held", int'(sample_valid), 1);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("t4_clr_valid", int'(sample_valid), 0);
        chk("t4_clr_overrun", int'(overrun), 0);
        chk("t4_clr_sample_kept", int'(sample), 255);

        // Reset in mid-window with a pending sample.
        data_mode = 1;
        do_reset(1'b0);
        wait_valid(400, n);
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_rst_valid", int'(sample_valid), 0);
        chk("t5_rst_sample", int'(sample), 0);
        chk("t5_rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        sample_ready = 1'b1;
        push_exp(8'd255, 6'd63, 1);
        wait_valid(400, n);
        chk("t5_latency", n, 258);

        // Sparse strobe: one window per 1024 clocks; accept and load on the same edge.
        data_mode = 1; en_mode = 1;
        do_reset(1'b1);
        push_exp(8'd255, 6'd63, 4);
        wait_valid(1200, n);
        wait_valid(1100, n);
        chk("t6_period", n, 1024);
        @(posedge clk);
        #1 sample_ready = 1'b0;
        repeat (2046) @(posedge clk);
        #1 sample_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid_before_end", int'(sample_valid), 1);
        @(posedge clk);
        #1 sample_ready = 1'b0;
        @(negedge clk);
        chk("t6_valid_stays", int'(sample_valid), 1);
        chk("t6_no_overrun", int'(overrun), 0);
        @(posedge clk);
        #1 sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
